// File: rtl/regdisp_nway.sv
// regdisp_nway: N-way register dispatcher with outstanding-transaction tracking.
//
// One upstream reg_native_if master is fanned out to FORWARD_NUM children.
// Each child owns an address window [BASE_ADDR+CH_BASE[i], +CH_SIZE[i]).
// A request that hits a window is forwarded with a rebased address. Only one
// transaction is outstanding at a time. The dispatcher answers unmapped
// accesses itself. It also answers accesses to quarantined children, and
// accesses whose child does not ack within TIMEOUT_CYCLES.
//
// Ports:
//   regdisp_nway_clk / regdisp_nway_rst    clock, synchronous active-high reset
//   upstream__regdisp_nway__*              upstream request (req_vld, addr, wr/rd, data, soft_rst)
//   regdisp_nway__upstream__*              upstream response (ack_vld, err, rd_data)
//   regdisp_nway__downstream__*            per-channel request, packed FORWARD_NUM wide
//   downstream__regdisp_nway__*            per-channel response, packed FORWARD_NUM wide
//   regdisp_nway__busy                     a forwarded transaction is outstanding
//   regdisp_nway__quarantine               per channel: timed out, late ack still pending
//   regdisp_nway__overrun                  sticky: an upstream request was dropped while busy
module regdisp_nway #(
    parameter int                          FORWARD_NUM     = 4,
    parameter int                          ADDR_WIDTH      = 48,
    parameter int                          DATA_WIDTH      = 32,
    parameter logic [63:0]                 BASE_ADDR       = 64'h0,
    parameter logic [FORWARD_NUM*64-1:0]   CH_BASE         = {FORWARD_NUM{64'h0}},
    parameter logic [FORWARD_NUM*64-1:0]   CH_SIZE         = {FORWARD_NUM{64'h1000}},
    parameter int                          TIMEOUT_CYCLES  = 256,
    parameter logic                        ERR_ON_UNMAPPED = 1'b1
) (
    input  logic                              regdisp_nway_clk,
    input  logic                              regdisp_nway_rst,
    input  logic                              upstream__regdisp_nway__req_vld,
    input  logic [ADDR_WIDTH-1:0]             upstream__regdisp_nway__addr,
    input  logic                              upstream__regdisp_nway__wr_en,
    input  logic                              upstream__regdisp_nway__rd_en,
    input  logic [DATA_WIDTH-1:0]             upstream__regdisp_nway__wr_data,
    input  logic                              upstream__regdisp_nway__soft_rst,
    output logic                              regdisp_nway__upstream__ack_vld,
    output logic                              regdisp_nway__upstream__err,
    output logic [DATA_WIDTH-1:0]             regdisp_nway__upstream__rd_data,
    output logic [FORWARD_NUM-1:0]            regdisp_nway__downstream__req_vld,
    output logic [FORWARD_NUM*ADDR_WIDTH-1:0] regdisp_nway__downstream__addr,
    output logic [FORWARD_NUM-1:0]            regdisp_nway__downstream__wr_en,
    output logic [FORWARD_NUM-1:0]            regdisp_nway__downstream__rd_en,
    output logic [FORWARD_NUM*DATA_WIDTH-1:0] regdisp_nway__downstream__wr_data,
    output logic [FORWARD_NUM-1:0]            regdisp_nway__downstream__soft_rst,
    input  logic [FORWARD_NUM-1:0]            downstream__regdisp_nway__ack_vld,
    input  logic [FORWARD_NUM-1:0]            downstream__regdisp_nway__err,
    input  logic [FORWARD_NUM*DATA_WIDTH-1:0] downstream__regdisp_nway__rd_data,
    output logic                              regdisp_nway__busy,
    output logic [FORWARD_NUM-1:0]            regdisp_nway__quarantine,
    output logic                              regdisp_nway__overrun
);

    localparam int SW = (FORWARD_NUM > 1) ? $clog2(FORWARD_NUM) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                        state_p0, state_p1;
    logic [CW-1:0]                 cnt_p0, cnt_p1;
    logic [SW-1:0]                 sel_p0, sel_p1;
    logic [FORWARD_NUM-1:0]        quar_p0, quar_p1;
    logic                          overrun_p0, overrun_p1;
    logic                          ack_p0, ack_p1;
    logic                          err_p0, err_p1;
    logic [DATA_WIDTH-1:0]         rdata_p0, rdata_p1;
    logic [FORWARD_NUM-1:0]        ds_req_p0, ds_req_p1;
    logic [FORWARD_NUM*ADDR_WIDTH-1:0] ds_addr_p0, ds_addr_p1;
    logic [FORWARD_NUM-1:0]        ds_wr_p0, ds_wr_p1;
    logic [FORWARD_NUM-1:0]        ds_rd_p0, ds_rd_p1;
    logic [FORWARD_NUM*DATA_WIDTH-1:0] ds_wdata_p0, ds_wdata_p1;
    logic [FORWARD_NUM-1:0]        ds_srst_p0, ds_srst_p1;

    logic                          hit_any;
    logic [SW-1:0]                 hit_idx;
    logic [ADDR_WIDTH-1:0]         hit_off;

    // Stage p0: window decode. Scanning from the top index down lets the
    // lowest matching index overwrite the result, so it wins on overlap.
    always_comb begin
        logic [63:0] addr64;
        logic [63:0] lo;
        logic [63:0] hi;
        addr64  = 64'(upstream__regdisp_nway__addr);
        lo      = '0;
        hi      = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = FORWARD_NUM - 1; i >= 0; i--) begin
            lo = BASE_ADDR + CH_BASE[i*64 +: 64];
            hi = lo + CH_SIZE[i*64 +: 64];
            if (addr64 >= lo && addr64 < hi) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
                hit_off = ADDR_WIDTH'(addr64 - lo);
            end
        end
    end

    // Stage p0: next-state and next-output logic. Every output register is
    // recomputed each cycle, so strobes and data fall back to 0 by default.
    always_comb begin
        state_p0    = state_p1;
        cnt_p0      = cnt_p1;
        sel_p0      = sel_p1;
        quar_p0     = quar_p1 & ~downstream__regdisp_nway__ack_vld;
        overrun_p0  = overrun_p1;
        ack_p0      = 1'b0;
        err_p0      = 1'b0;
        rdata_p0    = '0;
        ds_req_p0   = '0;
        ds_addr_p0  = '0;
        ds_wr_p0    = '0;
        ds_rd_p0    = '0;
        ds_wdata_p0 = '0;
        ds_srst_p0  = {FORWARD_NUM{upstream__regdisp_nway__soft_rst}};

        if (upstream__regdisp_nway__soft_rst) begin
            // Abandon any outstanding transaction without answering upstream.
            state_p0   = ST_IDLE;
            cnt_p0     = '0;
            quar_p0    = '0;
            overrun_p0 = 1'b0;
        end else begin
            case (state_p1)
                ST_IDLE: begin
                    if (upstream__regdisp_nway__req_vld) begin
                        if (!hit_any) begin
                            ack_p0 = 1'b1;
                            err_p0 = ERR_ON_UNMAPPED;
                        end else if (quar_p1[hit_idx]) begin
                            ack_p0 = 1'b1;
                            err_p0 = 1'b1;
                        end else begin
                            ds_req_p0[hit_idx]                           = 1'b1;
                            ds_addr_p0[hit_idx*ADDR_WIDTH +: ADDR_WIDTH] = hit_off;
                            ds_wr_p0[hit_idx]                            = upstream__regdisp_nway__wr_en;
                            ds_rd_p0[hit_idx]                            = upstream__regdisp_nway__rd_en;
                            ds_wdata_p0[hit_idx*DATA_WIDTH +: DATA_WIDTH] = upstream__regdisp_nway__wr_data;
                            sel_p0   = hit_idx;
                            cnt_p0   = '0;
                            state_p0 = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (upstream__regdisp_nway__req_vld) begin
                        overrun_p0 = 1'b1;
                    end
                    // The child's ack is checked before the timeout so a
                    // reply in the last counted cycle still goes through.
                    if (downstream__regdisp_nway__ack_vld[sel_p1]) begin
                        ack_p0   = 1'b1;
                        err_p0   = downstream__regdisp_nway__err[sel_p1];
                        rdata_p0 = downstream__regdisp_nway__rd_data[sel_p1*DATA_WIDTH +: DATA_WIDTH];
                        state_p0 = ST_IDLE;
                    end else if (cnt_p1 == CNT_LAST) begin
                        ack_p0          = 1'b1;
                        err_p0          = 1'b1;
                        quar_p0[sel_p1] = 1'b1;
                        state_p0        = ST_IDLE;
                    end else begin
                        cnt_p0 = cnt_p1 + 1'b1;
                    end
                end
                default: state_p0 = ST_IDLE;
            endcase
        end
    end

    // Stage p1: registered state and outputs.
    always_ff @(posedge regdisp_nway_clk) begin
        if (regdisp_nway_rst) begin
            state_p1    <= ST_IDLE;
            cnt_p1      <= '0;
            sel_p1      <= '0;
            quar_p1     <= '0;
            overrun_p1  <= 1'b0;
            ack_p1      <= 1'b0;
            err_p1      <= 1'b0;
            rdata_p1    <= '0;
            ds_req_p1   <= '0;
            ds_addr_p1  <= '0;
            ds_wr_p1    <= '0;
            ds_rd_p1    <= '0;
            ds_wdata_p1 <= '0;
            ds_srst_p1  <= '0;
        end else begin
            state_p1    <= state_p0;
            cnt_p1      <= cnt_p0;
            sel_p1      <= sel_p0;
            quar_p1     <= quar_p0;
            overrun_p1  <= overrun_p0;
            ack_p1      <= ack_p0;
            err_p1      <= err_p0;
            rdata_p1    <= rdata_p0;
            ds_req_p1   <= ds_req_p0;
            ds_addr_p1  <= ds_addr_p0;
            ds_wr_p1    <= ds_wr_p0;
            ds_rd_p1    <= ds_rd_p0;
            ds_wdata_p1 <= ds_wdata_p0;
            ds_srst_p1  <= ds_srst_p0;
        end
    end

    assign regdisp_nway__upstream__ack_vld     = ack_p1;
    assign regdisp_nway__upstream__err         = err_p1;
    assign regdisp_nway__upstream__rd_data     = rdata_p1;
    assign regdisp_nway__downstream__req_vld   = ds_req_p1;
    assign regdisp_nway__downstream__addr      = ds_addr_p1;
    assign regdisp_nway__downstream__wr_en     = ds_wr_p1;
    assign regdisp_nway__downstream__rd_en     = ds_rd_p1;
    assign regdisp_nway__downstream__wr_data   = ds_wdata_p1;
    assign regdisp_nway__downstream__soft_rst  = ds_srst_p1;
    assign regdisp_nway__busy                  = (state_p1 == ST_WAIT);
    assign regdisp_nway__quarantine            = quar_p1;
    assign regdisp_nway__overrun               = overrun_p1;

endmodule

// File: tb/tb_regdisp_nway.sv
// Directed bench for regdisp_nway: FORWARD_NUM=4, windows 0x0/0x1000/0x2000/0x3000,
// size 0x1000 each, TIMEOUT_CYCLES=8. A second instance with ERR_ON_UNMAPPED=0
// shares the inputs and is only inspected for the unmapped-access response.
module tb_regdisp_nway;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_vld, wr_en, rd_en, soft_rst;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    c_ack, c_err;
    logic [N*DW-1:0] c_rdata;

    logic            up_ack, up_err, busy, overrun;
    logic [DW-1:0]   up_rdata;
    logic [N-1:0]    ds_req, ds_wr, ds_rd, ds_srst, quar;
    logic [N*AW-1:0] ds_addr;
    logic [N*DW-1:0] ds_wdata;

    logic            u1_ack, u1_err, u1_busy, u1_overrun;
    logic [DW-1:0]   u1_rdata;
    logic [N-1:0]    u1_req, u1_wr, u1_rd, u1_srst, u1_quar;
    logic [N*AW-1:0] u1_addr;
    logic [N*DW-1:0] u1_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regdisp_nway #(
        .FORWARD_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(64'h0),
        .CH_BASE({64'h3000, 64'h2000, 64'h1000, 64'h0}),
        .CH_SIZE({4{64'h1000}}), .TIMEOUT_CYCLES(8), .ERR_ON_UNMAPPED(1'b1)
    ) u_dut (
        .regdisp_nway_clk(clk), .regdisp_nway_rst(rst),
        .upstream__regdisp_nway__req_vld(req_vld), .upstream__regdisp_nway__addr(addr),
        .upstream__regdisp_nway__wr_en(wr_en), .upstream__regdisp_nway__rd_en(rd_en),
        .upstream__regdisp_nway__wr_data(wdata), .upstream__regdisp_nway__soft_rst(soft_rst),
        .regdisp_nway__upstream__ack_vld(up_ack), .regdisp_nway__upstream__err(up_err),
        .regdisp_nway__upstream__rd_data(up_rdata),
        .regdisp_nway__downstream__req_vld(ds_req), .regdisp_nway__downstream__addr(ds_addr),
        .regdisp_nway__downstream__wr_en(ds_wr), .regdisp_nway__downstream__rd_en(ds_rd),
        .regdisp_nway__downstream__wr_data(ds_wdata), .regdisp_nway__downstream__soft_rst(ds_srst),
        .downstream__regdisp_nway__ack_vld(c_ack), .downstream__regdisp_nway__err(c_err),
        .downstream__regdisp_nway__rd_data(c_rdata),
        .regdisp_nway__busy(busy), .regdisp_nway__quarantine(quar), .regdisp_nway__overrun(overrun)
    );

    regdisp_nway #(
        .FORWARD_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(64'h0),
        .CH_BASE({64'h3000, 64'h2000, 64'h1000, 64'h0}),
        .CH_SIZE({4{64'h1000}}), .TIMEOUT_CYCLES(8), .ERR_ON_UNMAPPED(1'b0)
    ) u_dut_noerr (
        .regdisp_nway_clk(clk), .regdisp_nway_rst(rst),
        .upstream__regdisp_nway__req_vld(req_vld), .upstream__regdisp_nway__addr(addr),
        .upstream__regdisp_nway__wr_en(wr_en), .upstream__regdisp_nway__rd_en(rd_en),
        .upstream__regdisp_nway__wr_data(wdata), .upstream__regdisp_nway__soft_rst(soft_rst),
        .regdisp_nway__upstream__ack_vld(u1_ack), .regdisp_nway__upstream__err(u1_err),
        .regdisp_nway__upstream__rd_data(u1_rdata),
        .regdisp_nway__downstream__req_vld(u1_req), .regdisp_nway__downstream__addr(u1_addr),
        .regdisp_nway__downstream__wr_en(u1_wr), .regdisp_nway__downstream__rd_en(u1_rd),
        .regdisp_nway__downstream__wr_data(u1_wdata), .regdisp_nway__downstream__soft_rst(u1_srst),
        .downstream__regdisp_nway__ack_vld(c_ack), .downstream__regdisp_nway__err(c_err),
        .downstream__regdisp_nway__rd_data(c_rdata),
        .regdisp_nway__busy(u1_busy), .regdisp_nway__quarantine(u1_quar), .regdisp_nway__overrun(u1_overrun)
    );

    typedef struct {
        string          name;
        logic [AW-1:0]  addr;
        logic           wr;
        logic [DW-1:0]  wdata;
        logic [N-1:0]   exp_req;    // downstream req_vld one cycle after the request
        logic [AW-1:0]  exp_addr;   // rebased address on the selected channel
        int             ack_dly;    // child acks in cycle T+ack_dly (0 = never)
        logic [DW-1:0]  ack_data;
        logic           ack_err;
        int             exp_n;      // upstream ack expected in cycle T+exp_n
        logic           exp_err;
        logic [DW-1:0]  exp_rdata;
        logic [N-1:0]   exp_q;      // quarantine after the transaction settles
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        c_ack = '0; c_err = '0; c_rdata = '0;
    endtask

    // Issue one request in cycle T, play the child's reply and watch upstream
    // for 20 cycles. Starts and ends at #1 after a rising edge.
    task automatic run_vec(input vec_t v);
        int ch, got_n, nacks, idle_bad;
        logic got_err;
        logic [DW-1:0] got_data;
        logic [N*AW-1:0] e_addr;
        logic [N*DW-1:0] e_wdata;
        ch = 0;
        for (int i = 0; i < N; i++) if (v.exp_req[i]) ch = i;
        e_addr = '0;
        e_wdata = '0;
        if (v.exp_req != '0) begin
            e_addr[ch*AW +: AW]  = v.exp_addr;
            e_wdata[ch*DW +: DW] = v.wr ? v.wdata : '0;
        end
        got_n = -1; nacks = 0; idle_bad = 0; got_err = 1'b0; got_data = '0;
        req_vld = 1'b1; addr = v.addr; wr_en = v.wr; rd_en = !v.wr; wdata = v.wdata;
        tick();
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        for (int n = 1; n <= 20; n++) begin
            if (up_ack) begin
                nacks++;
                if (got_n < 0) begin got_n = n; got_err = up_err; got_data = up_rdata; end
            end else if (up_rdata != '0) begin
                idle_bad++;
            end
            if (n == 1) begin
                chk({v.name, " ds_req"},   256'(ds_req),   256'(v.exp_req));
                chk({v.name, " ds_addr"},  256'(ds_addr),  256'(e_addr));
                chk({v.name, " ds_wdata"}, 256'(ds_wdata), 256'(e_wdata));
                chk({v.name, " ds_wr"},    256'(ds_wr),    256'(v.wr ? v.exp_req : 4'b0));
                chk({v.name, " busy"},     256'(busy),     256'(v.exp_req != '0));
            end
            c_ack = '0; c_err = '0; c_rdata = '0;
            if (n == v.ack_dly) begin
                c_ack[ch] = 1'b1; c_err[ch] = v.ack_err; c_rdata[ch*DW +: DW] = v.ack_data;
            end
            tick();
        end
        c_ack = '0; c_err = '0; c_rdata = '0;
        chk({v.name, " ack_cycle"},  256'(got_n),    256'(v.exp_n));
        chk({v.name, " ack_count"},  256'(nacks),    256'(1));
        chk({v.name, " err"},        256'(got_err),  256'(v.exp_err));
        chk({v.name, " rd_data"},    256'(got_data), 256'(v.exp_rdata));
        chk({v.name, " idle_rdata"}, 256'(idle_bad), 256'(0));
        chk({v.name, " quarantine"}, 256'(quar),     256'(v.exp_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacks;
        vecs[0] = '{"rd_ch2",     48'h2010, 1'b0, 32'h0,        4'b0100, 48'h10,  3, 32'hA5A5_0001, 1'b0, 4, 1'b0, 32'hA5A5_0001, 4'b0};
        vecs[1] = '{"wr_unmap",   48'h5000, 1'b1, 32'h1111_2222, 4'b0000, 48'h0,   0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         4'b0};
        vecs[2] = '{"rd_ch0_err", 48'h0004, 1'b0, 32'h0,        4'b0001, 48'h4,   1, 32'h1234_5678, 1'b1, 2, 1'b1, 32'h1234_5678, 4'b0};
        vecs[3] = '{"wr_ch3_top", 48'h3FFC, 1'b1, 32'hCAFE_F00D, 4'b1000, 48'hFFC, 2, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 32'hDEAD_BEEF, 4'b0};
        vecs[4] = '{"rd_ch1_low", 48'h1000, 1'b0, 32'h0,        4'b0010, 48'h0,   5, 32'hCAFE_0000, 1'b0, 6, 1'b0, 32'hCAFE_0000, 4'b0};
        vecs[5] = '{"rd_abv_ch3", 48'h4000, 1'b0, 32'h0,        4'b0000, 48'h0,   0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         4'b0};
        vecs[6] = '{"ack_at_7",   48'h0008, 1'b0, 32'h0,        4'b0001, 48'h8,   8, 32'h0BAD_F00D, 1'b0, 9, 1'b0, 32'h0BAD_F00D, 4'b0};
        vecs[7] = '{"timeout",    48'h1020, 1'b0, 32'h0,        4'b0010, 48'h20,  0, 32'h0,         1'b0, 9, 1'b1, 32'h0,         4'b0010};
        vecs[8] = '{"quar_hit",   48'h1004, 1'b0, 32'h0,        4'b0000, 48'h0,   0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         4'b0010};

        clear_inputs();
        soft_rst = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst ack",      256'(up_ack),  256'(0));
        chk("rst busy",     256'(busy),    256'(0));
        chk("rst quar",     256'(quar),    256'(0));
        chk("rst overrun",  256'(overrun), 256'(0));
        chk("rst ds_req",   256'(ds_req),  256'(0));
        chk("rst ds_srst",  256'(ds_srst), 256'(0));

        // Unmapped write against the ERR_ON_UNMAPPED=0 instance.
        req_vld = 1'b1; addr = 48'h5000; wr_en = 1'b1; wdata = 32'h55;
        tick();
        clear_inputs();
        chk("noerr ack",    256'(u1_ack),   256'(1));
        chk("noerr err",    256'(u1_err),   256'(0));
        chk("noerr rdata",  256'(u1_rdata), 256'(0));
        chk("noerr ds_req", 256'(u1_req),   256'(0));
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Late ack from quarantined ch1: clears quarantine, nothing upstream.
        c_ack[1] = 1'b1; c_rdata[DW +: DW] = 32'h9999_9999;
        tick();
        c_ack = '0; c_rdata = '0;
        chk("late quar",  256'(quar),   256'(0));
        chk("late ack",   256'(up_ack), 256'(0));
        tick();
        chk("late ack2",  256'(up_ack), 256'(0));

        // Second request while WAITing on ch2 is dropped and flags overrun.
        req_vld = 1'b1; addr = 48'h2000; rd_en = 1'b1;
        tick();
        chk("ovr ds_req", 256'(ds_req), 256'(4'b0100));
        addr = 48'h0;
        c_ack[2] = 1'b1; c_rdata[2*DW +: DW] = 32'h0000_0077;
        tick();
        clear_inputs();
        chk("ovr ack",     256'(up_ack),   256'(1));
        chk("ovr rdata",   256'(up_rdata), 256'(32'h77));
        chk("ovr overrun", 256'(overrun),  256'(1));
        nacks = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (up_ack || ds_req != '0) nacks++;
        end
        chk("ovr no extra", 256'(nacks),   256'(0));
        chk("ovr sticky",   256'(overrun), 256'(1));

        // soft_rst pulse while WAITing on ch0.
        req_vld = 1'b1; addr = 48'h0010; rd_en = 1'b1;
        tick();
        clear_inputs();
        tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("srst bcast",   256'(ds_srst), 256'(4'hF));
        chk("srst busy",    256'(busy),    256'(0));
        chk("srst overrun", 256'(overrun), 256'(0));
        nacks = 0;
        for (int n = 0; n < 10; n++) begin
            if (up_ack) nacks++;
            if (n == 1) chk("srst bcast off", 256'(ds_srst), 256'(0));
            tick();
        end
        chk("srst no ack", 256'(nacks), 256'(0));
        run_vec('{"after_srst", 48'h0000, 1'b0, 32'h0, 4'b0001, 48'h0, 2, 32'h0000_ABCD, 1'b0, 3, 1'b0, 32'h0000_ABCD, 4'b0});

        // Mid-operation reset abandons the outstanding transaction silently.
        req_vld = 1'b1; addr = 48'h3000; rd_en = 1'b1;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst busy", 256'(busy),   256'(0));
        nacks = 0;
        for (int n = 0; n < 10; n++) begin
            if (up_ack) nacks++;
            tick();
        end
        chk("mid rst no ack", 256'(nacks), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regdisp_nway.md
Name: regdisp_nway

Overview:
Parametrised N-way register dispatcher with outstanding-transaction tracking. It sits between one upstream reg_native_if master and FORWARD_NUM downstream regslv/regdisp children. It decodes per-channel address windows, rebases the address and forwards one transaction at a time. It returns the selected child's response, answers unmapped or timed-out accesses itself, and quarantines children that miss the timeout.

Parameters:
FORWARD_NUM, 4, number of downstream channels (1..16)
ADDR_WIDTH, 48, upstream and downstream address width
DATA_WIDTH, 32, data width (multiple of 8)
BASE_ADDR, 64'h0, absolute base of this dispatcher
CH_BASE, {FORWARD_NUM{64'h0}}, packed 64-bit window offset per channel, relative to BASE_ADDR
CH_SIZE, {FORWARD_NUM{64'h1000}}, packed 64-bit window size in bytes per channel (nonzero)
TIMEOUT_CYCLES, 256, WAIT cycles before self-timeout (>=2)
ERR_ON_UNMAPPED, 1, err value returned for unmapped accesses

Ports:
regdisp_nway_clk  in  1  clock
regdisp_nway_rst  in  1  reset, synchronous, active-high
upstream__regdisp_nway__req_vld  in  1  request strobe
upstream__regdisp_nway__addr  in  ADDR_WIDTH  absolute byte address
upstream__regdisp_nway__wr_en  in  1  write
upstream__regdisp_nway__rd_en  in  1  read
upstream__regdisp_nway__wr_data  in  DATA_WIDTH  write data
upstream__regdisp_nway__soft_rst  in  1  soft reset
regdisp_nway__upstream__ack_vld  out  1  response strobe
regdisp_nway__upstream__err  out  1  response error
regdisp_nway__upstream__rd_data  out  DATA_WIDTH  read data
regdisp_nway__downstream__req_vld  out  FORWARD_NUM  per-channel request
regdisp_nway__downstream__addr  out  FORWARD_NUM*ADDR_WIDTH  rebased address
regdisp_nway__downstream__wr_en  out  FORWARD_NUM  per-channel write
regdisp_nway__downstream__rd_en  out  FORWARD_NUM  per-channel read
regdisp_nway__downstream__wr_data  out  FORWARD_NUM*DATA_WIDTH  write data
regdisp_nway__downstream__soft_rst  out  FORWARD_NUM  soft reset broadcast
downstream__regdisp_nway__ack_vld  in  FORWARD_NUM  per-channel ack
downstream__regdisp_nway__err  in  FORWARD_NUM  per-channel err
downstream__regdisp_nway__rd_data  in  FORWARD_NUM*DATA_WIDTH  per-channel read data
regdisp_nway__busy  out  1  transaction outstanding
regdisp_nway__quarantine  out  FORWARD_NUM  channel timed out, late ack pending
regdisp_nway__overrun  out  1  sticky: request dropped while busy

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered and 0 in reset; FSM = IDLE; counters cleared.
- Decode: hit[i] = BASE_ADDR+CH_BASE[i] <= addr < BASE_ADDR+CH_BASE[i]+CH_SIZE[i], compared at 64 bits with addr zero-extended. On overlapping windows the lowest index wins. Rebased addr = addr - (BASE_ADDR+CH_BASE[i]), truncated to ADDR_WIDTH. Non-selected channels drive 0.
- FSM IDLE, req_vld at cycle T:
  - Hit on a non-quarantined channel i: in T+1, downstream req_vld[i]=1 for exactly one cycle with addr/wr_en/rd_en/wr_data. Go to WAIT, cnt=0.
  - Unmapped: upstream ack_vld=1 in T+1, err=ERR_ON_UNMAPPED, rd_data=0. Stay in IDLE.
  - Hit on a quarantined channel: ack in T+1, err=1, rd_data=0. Nothing forwarded.
- WAIT (includes the downstream req cycle):
  - ack_vld[sel] in cycle A: upstream ack_vld=1, err=err[sel], rd_data=rd_data[sel] in A+1. Go to IDLE.
  - Otherwise cnt increments. At cnt==TIMEOUT_CYCLES-1 with no ack, upstream ack_vld=1, err=1, rd_data=0 next cycle; quarantine[sel] set; go to IDLE.
  - Ack and timeout in the same cycle: ack wins, no quarantine.
- Acks from unselected channels are ignored. A quarantined channel's ack clears its quarantine bit next cycle and is never forwarded upstream.
- Upstream req_vld in WAIT, or in the cycle that leaves WAIT, is dropped: overrun set (sticky), no ack generated.
- busy = (state == WAIT).
- Upstream ack_vld is a single-cycle pulse; rd_data is 0 whenever ack_vld=0.
- soft_rst:
  - Broadcast registered to all channels (1-cycle delay).
  - While high: FSM to IDLE with no upstream ack; quarantine, overrun and cnt cleared; requests ignored.
- Mid-operation reset: same as power-on; an outstanding transaction is abandoned silently.

Test Plan:
- FORWARD_NUM=4, CH_BASE={0x3000,0x2000,0x1000,0}, CH_SIZE=0x1000 each; read 0x2010 at T; ch2 acks rd_data=0xA5A5_0001 at T+3 -> downstream req_vld=4'b0100 and addr=0x10 at T+1; upstream ack with 0xA5A5_0001, err=0 at T+4.
- Write 0x5000 (unmapped) -> no downstream req; ack, err=1, rd_data=0 at T+1. Repeat with ERR_ON_UNMAPPED=0 -> err=0.
- TIMEOUT_CYCLES=8, ch1 never acks -> ack err=1 exactly 8 cycles after the downstream req cycle; quarantine=4'b0010. Next access to ch1 -> err=1 at T+1. Late ch1 ack -> quarantine cleared, no upstream ack.
- Second req_vld during WAIT -> ignored, overrun=1, exactly one upstream ack.
- ch0 acks in the cycle cnt reaches 7 -> normal response, err=0, quarantine stays 0.
- soft_rst pulse during WAIT -> downstream soft_rst=4'hF one cycle later; busy=0, no ack; subsequent read of 0x0 completes normally.
